board_scanner: RTL and testbench

- Reader-side counterpart to the button FSM that writes the 3x3 game board into the register array.
- On request, fetches all nine 2-bit cells through a synchronous read port and evaluates the eight win lines in sequence.
- Reports win, draw or no result, plus the winning-line cell mask, so top level can drive game-over state and highlighting.

---
 rtl/board_scanner.sv | 157 +++++++++++++++
 tb/tb_board_scanner.sv | 131 +++++++++++++
 2 files changed

// File: rtl/board_scanner.sv
// Reads the nine 3x3 board cells, evaluates the eight win lines and reports win/draw/none.
// Latency: start to done = 18 + READ_LAT cycles. No backpressure: start while busy is dropped.
// BOARD_SCANNER_WIN_MASK_EN: when defined, win_mask reports the winning line; otherwise it is tied to 0.
module board_scanner #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 2,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        result,
    output logic [8:0]        win_mask
);

    typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} stateT;

    stateT               state;
    logic                issuing;
    logic [READ_LAT-1:0] vldPipe;
    logic [3:0]          capIdx;
    logic [2:0]          lineIdx;
    logic [DATA_W-1:0]   snapshot [9];
    logic                found;
    logic [DATA_W-1:0]   foundVal;

    logic [3:0]          idxA, idxB, idxC;
    logic [DATA_W-1:0]   cellA, cellB, cellC;
    logic                lineMatch, allFilled, effFound;
    logic [DATA_W-1:0]   effVal;

    // Fixed evaluation order: rows, columns, diagonal, anti-diagonal.
    always_comb begin
        idxA = 4'd0; idxB = 4'd1; idxC = 4'd2;
        case (lineIdx)
            3'd0: begin idxA = 4'd0; idxB = 4'd1; idxC = 4'd2; end
            3'd1: begin idxA = 4'd3; idxB = 4'd4; idxC = 4'd5; end
            3'd2: begin idxA = 4'd6; idxB = 4'd7; idxC = 4'd8; end
            3'd3: begin idxA = 4'd0; idxB = 4'd3; idxC = 4'd6; end
            3'd4: begin idxA = 4'd1; idxB = 4'd4; idxC = 4'd7; end
            3'd5: begin idxA = 4'd2; idxB = 4'd5; idxC = 4'd8; end
            3'd6: begin idxA = 4'd0; idxB = 4'd4; idxC = 4'd8; end
            default: begin idxA = 4'd2; idxB = 4'd4; idxC = 4'd6; end
        endcase
    end

    assign cellA     = snapshot[idxA];
    assign cellB     = snapshot[idxB];
    assign cellC     = snapshot[idxC];
    assign lineMatch = (cellA == cellB) && (cellB == cellC) &&
                       ((cellA == DATA_W'(1)) || (cellA == DATA_W'(2)));
    assign effFound  = found || lineMatch;
    assign effVal    = found ? foundVal : cellA;

    always_comb begin
        allFilled = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (snapshot[i] == '0) allFilled = 1'b0;
        end
    end

`ifdef BOARD_SCANNER_WIN_MASK_EN
    logic [8:0] lineMask, foundMask, effMask, winMaskQ;
    assign lineMask = (9'd1 << idxA) | (9'd1 << idxB) | (9'd1 << idxC);
    assign effMask  = found ? foundMask : lineMask;
    assign win_mask = winMaskQ;
`else
    assign win_mask = 9'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_addr  <= '0;
            issuing  <= 1'b0;
            vldPipe  <= '0;
            capIdx   <= 4'd0;
            lineIdx  <= 3'd0;
            found    <= 1'b0;
            foundVal <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= 2'b00;
            for (int i = 0; i < 9; i++) snapshot[i] <= '0;
`ifdef BOARD_SCANNER_WIN_MASK_EN
            foundMask <= 9'd0;
            winMaskQ  <= 9'd0;
`endif
        end else begin
            // vldPipe[READ_LAT-1] marks the cycle rd_data answers a valid address.
            for (int i = READ_LAT - 1; i > 0; i--) vldPipe[i] <= vldPipe[i-1];
            vldPipe[0] <= issuing;

            case (state)
                IDLE: begin
                    rd_addr <= '0;
                    if (start) begin
                        state   <= FETCH;
                        busy    <= 1'b1;
                        issuing <= 1'b1;
                        capIdx  <= 4'd0;
                        found   <= 1'b0;
                    end
                end
                FETCH: begin
                    if (issuing) begin
                        if (rd_addr == ADDR_W'(8)) begin
                            rd_addr <= '0;
                            issuing <= 1'b0;
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                    if (vldPipe[READ_LAT-1]) begin
                        snapshot[capIdx] <= rd_data;
                        if (capIdx == 4'd8) begin
                            state   <= EVAL;
                            lineIdx <= 3'd0;
                        end else begin
                            capIdx <= capIdx + 4'd1;
                        end
                    end
                end
                EVAL: begin
                    if (!found && lineMatch) begin
                        found    <= 1'b1;
                        foundVal <= cellA;
`ifdef BOARD_SCANNER_WIN_MASK_EN
                        foundMask <= lineMask;
`endif
                    end
                    // Outputs are registered on the way into DONE so they are visible with the pulse.
                    if (lineIdx == 3'd7) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= effFound ? 2'(effVal) : (allFilled ? 2'b11 : 2'b00);
`ifdef BOARD_SCANNER_WIN_MASK_EN
                        winMaskQ <= effFound ? effMask : 9'd0;
`endif
                    end else begin
                        lineIdx <= lineIdx + 3'd1;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench: two scanners (READ_LAT 1 and 3) scan hand-built boards behind modelled read ports.
module tb_board_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start1, start3;
    logic [3:0] addr1, addr3;
    logic [1:0] rdData1, rdData3, result1, result3;
    logic       busy1, busy3, done1, done3;
    logic [8:0] mask1, mask3;

    logic [1:0] board [16];
    logic [3:0] a1, a3s0, a3s1, a3s2;

    int vecCnt  = 0;
    int missCnt = 0;

    board_scanner #(.ADDR_W(4), .DATA_W(2), .READ_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rd_addr(addr1), .rd_data(rdData1),
        .busy(busy1), .done(done1), .result(result1), .win_mask(mask1)
    );

    board_scanner #(.ADDR_W(4), .DATA_W(2), .READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .rd_addr(addr3), .rd_data(rdData3),
        .busy(busy3), .done(done3), .result(result3), .win_mask(mask3)
    );

    // Register-array read ports with 1 and 3 cycles of latency.
    always_ff @(posedge clk) begin
        a1   <= addr1;
        a3s0 <= addr3;
        a3s1 <= a3s0;
        a3s2 <= a3s1;
    end
    assign rdData1 = board[a1];
    assign rdData3 = board[a3s2];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            missCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic runScan(input string name, input logic [17:0] brd, input logic [1:0] expRes,
                           input logic [8:0] expMask, input bit reassert, input int rstCyc,
                           input bit detail);
        int doneAt1 = 0, doneAt3 = 0, doneN1 = 0, doneN3 = 0;
        logic [1:0] r1 = 2'b00, r3 = 2'b00;
        logic [8:0] m1 = 9'd0, m3 = 9'd0, em;
`ifdef BOARD_SCANNER_WIN_MASK_EN
        em = expMask;
`else
        em = 9'd0;
`endif
        for (int k = 0; k < 9; k++) board[k] = brd[2*k +: 2];
        @(negedge clk);
        start1 = 1'b1;
        start3 = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done1) begin doneN1++; if (doneAt1 == 0) doneAt1 = n; r1 = result1; m1 = mask1; end
            if (done3) begin doneN3++; if (doneAt3 == 0) doneAt3 = n; r3 = result3; m3 = mask3; end
            if (detail && n <= 10)
                checkVal($sformatf("%s rd_addr c%0d", name, n), 32'(addr1), (n <= 9) ? n - 1 : 0);
            if (detail && (n == 1 || n == 19 || n == 20))
                checkVal($sformatf("%s busy1 c%0d", name, n), 32'(busy1), (n <= 19) ? 1 : 0);
            if (detail && (n == 21 || n == 22))
                checkVal($sformatf("%s busy3 c%0d", name, n), 32'(busy3), (n == 21) ? 1 : 0);
            if (rstCyc != 0 && n == rstCyc + 1) begin
                checkVal({name, " busy1 after rst"}, 32'(busy1), 0);
                checkVal({name, " busy3 after rst"}, 32'(busy3), 0);
            end
            start1 = reassert && (n == 5 || n == 19);
            start3 = reassert && (n == 5 || n == 21);
            rst    = (rstCyc != 0 && n == rstCyc);
        end
        if (rstCyc != 0) begin
            checkVal({name, " done1 count"}, 32'(doneN1), 0);
            checkVal({name, " done3 count"}, 32'(doneN3), 0);
            checkVal({name, " result1"}, 32'(result1), 0);
            checkVal({name, " result3"}, 32'(result3), 0);
        end else begin
            checkVal({name, " done1 cycle"}, 32'(doneAt1), 19);
            checkVal({name, " done3 cycle"}, 32'(doneAt3), 21);
            checkVal({name, " done1 count"}, 32'(doneN1), 1);
            checkVal({name, " done3 count"}, 32'(doneN3), 1);
            checkVal({name, " result1"}, 32'(r1), 32'(expRes));
            checkVal({name, " result3"}, 32'(r3), 32'(expRes));
            checkVal({name, " mask1"}, 32'(m1), 32'(em));
            checkVal({name, " mask3"}, 32'(m3), 32'(em));
            checkVal({name, " result1 hold"}, 32'(result1), 32'(expRes));
            checkVal({name, " mask3 hold"}, 32'(mask3), 32'(em));
        end
    endtask

    initial begin
        rst    = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        for (int k = 0; k < 16; k++) board[k] = 2'b00;
        repeat (3) @(negedge clk);
        checkVal("reset busy", 32'(busy1), 0);
        checkVal("reset done", 32'(done1), 0);
        checkVal("reset result", 32'(result1), 0);
        checkVal("reset rd_addr", 32'(addr1), 0);
        checkVal("reset win_mask", 32'(mask1), 0);
        checkVal("reset busy3", 32'(busy3), 0);
        rst = 1'b0;
        @(negedge clk);

        // Boards written as {c8,c7,...,c0}, two bits per cell.
        runScan("empty",     18'b00_00_00_00_00_00_00_00_00, 2'b00, 9'h000, 1'b0, 0, 1'b1);
        runScan("row0_p1",   18'b00_00_00_00_00_00_01_01_01, 2'b01, 9'h007, 1'b0, 0, 1'b0);
        runScan("anti_p2",   18'b00_01_10_00_10_01_10_00_01, 2'b10, 9'h054, 1'b0, 0, 1'b0);
        runScan("draw",      18'b01_01_10_10_10_01_01_10_01, 2'b11, 9'h000, 1'b0, 0, 1'b0);
        runScan("draw_inv",  18'b01_01_10_10_11_01_01_10_01, 2'b11, 9'h000, 1'b0, 0, 1'b0);
        runScan("inv_row",   18'b00_00_00_00_00_00_01_11_01, 2'b00, 9'h000, 1'b0, 0, 1'b0);
        runScan("first_win", 18'b00_00_00_10_10_10_01_01_01, 2'b01, 9'h007, 1'b0, 0, 1'b0);
        runScan("reassert",  18'b00_00_00_10_10_10_01_01_01, 2'b01, 9'h007, 1'b1, 0, 1'b0);
        runScan("row2_p2",   18'b10_10_10_00_00_00_00_00_00, 2'b10, 9'h1c0, 1'b0, 0, 1'b0);
        runScan("rst_fetch", 18'b10_10_10_00_00_00_00_00_00, 2'b00, 9'h000, 1'b0, 5, 1'b0);
        runScan("after_rst", 18'b10_10_10_00_00_00_00_00_00, 2'b10, 9'h1c0, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
